// File: rtl/op_combine_pipe.sv
// -----------------------------------------------------------------------------
// op_combine_pipe
//
// Buffered operand combiner. Each accepted (a, b, mode) triple produces one
// WIDTH-bit result: a bitwise OR / AND / XOR of the operands, or a "splice"
// that packs the low SPLIT bits of a on top, the upper bits of b in the
// middle and the low KEEP bits of the previous result at the bottom.
// Results are queued in a DEPTH-entry FIFO with valid/ready handshakes on
// the input and output sides.
//
// Parameters
//   WIDTH   operand/result width
//   SPLIT   low bits of a placed at the top of a splice result (>= 1)
//   KEEP    low bits of the previous result retained by a splice (>= 0)
//   DEPTH   result FIFO entries (power of two, >= 2)
//   SPLIT + KEEP must be smaller than WIDTH.
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   mode       in   2      0 = splice, 1 = OR, 2 = AND, 3 = XOR
//   in_valid   in   1      a/b/mode valid
//   in_ready   out  1      block can accept a triple
//   c          out  WIDTH  FIFO head result, 0 when out_valid = 0
//   out_valid  out  1      c valid
//   out_ready  in   1      consumer takes c
//   prev       out  WIDTH  only with OP_COMBINE_HIST_EN: result of the accept
//                          before the most recent one
//
// Build option
//   OP_COMBINE_HIST_EN  when defined, adds the prev port and its register.
//
// All outputs come from registers or are decoded from registers only; there
// is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module op_combine_pipe #(
    parameter int WIDTH = 32,
    parameter int SPLIT = 11,
    parameter int KEEP  = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] c,
    output logic             out_valid,
`ifdef OP_COMBINE_HIST_EN
    input  logic             out_ready,
    output logic [WIDTH-1:0] prev
`else
    input  logic             out_ready
`endif
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    // Mask selecting the retained low bits of the previous result; all zero
    // when KEEP = 0 so the splice then carries no history bits at all.
    localparam logic [WIDTH-1:0] KEEP_MASK =
        (KEEP == 0) ? {WIDTH{1'b0}} : ({WIDTH{1'b1}} >> (WIDTH - KEEP));

    // -------------------------------------------------------------------------
    // Elaboration-time legality checks
    // -------------------------------------------------------------------------
    if (SPLIT + KEEP >= WIDTH) begin : g_bad_split_keep
        $error("op_combine_pipe: SPLIT+KEEP (%0d) must be < WIDTH (%0d)",
               SPLIT + KEEP, WIDTH);
    end
    if (SPLIT < 1) begin : g_bad_split
        $error("op_combine_pipe: SPLIT (%0d) must be >= 1", SPLIT);
    end
    if (KEEP < 0) begin : g_bad_keep
        $error("op_combine_pipe: KEEP (%0d) must be >= 0", KEEP);
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("op_combine_pipe: DEPTH (%0d) must be a power of 2 and >= 2",
               DEPTH);
    end

    // -------------------------------------------------------------------------
    // Result function
    // -------------------------------------------------------------------------
    // Splice layout (MSB..LSB): x[SPLIT-1:0] | y[WIDTH-1:SPLIT+KEEP] | l[KEEP-1:0].
    // Built from shifts and a mask so that KEEP = 0 needs no special slicing.
    function automatic logic [WIDTH-1:0] combine_f(
        input logic [1:0]       m,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] l
    );
        logic [WIDTH-1:0] res;
        case (m)
            2'd0: res = (x << (WIDTH - SPLIT))
                      | ((y >> (SPLIT + KEEP)) << KEEP)
                      | (l & KEEP_MASK);
            2'd1: res = x | y;
            2'd2: res = x & y;
            2'd3: res = x ^ y;
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic [WIDTH-1:0] last_q,   last_d;
`ifdef OP_COMBINE_HIST_EN
    logic [WIDTH-1:0] prev_q,   prev_d;
`endif

    logic             accept_s;
    logic             pop_s;
    logic [WIDTH-1:0] result_s;

    // Handshake decode: in_ready and out_valid depend on count_q only, so
    // a full FIFO never accepts even while the consumer is popping.
    always_comb begin
        in_ready  = (count_q < CNT_DEPTH);
        out_valid = (count_q != {CW{1'b0}});
        accept_s  = in_valid & in_ready;
        pop_s     = out_valid & out_ready;
        result_s  = combine_f(mode, a, b, last_q);
    end

    // Head of queue is forced to zero whenever nothing is queued.
    always_comb begin
        if (out_valid) begin
            c = mem_q[rd_ptr_q];
        end else begin
            c = {WIDTH{1'b0}};
        end
    end

`ifdef OP_COMBINE_HIST_EN
    // Expose the history register.
    always_comb begin
        prev = prev_q;
    end
`endif

    // FIFO storage next-state: only the tail slot is written on accept.
    always_comb begin
        mem_d = mem_q;
        if (accept_s) begin
            mem_d[wr_ptr_q] = result_s;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end
    end

    // Pointer, occupancy and history next-state. Pointers wrap naturally at
    // DEPTH because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
`ifdef OP_COMBINE_HIST_EN
        prev_d   = prev_q;
`endif

        if (accept_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            last_d   = result_s;
`ifdef OP_COMBINE_HIST_EN
            // prev captures last before it is overwritten by this accept.
            prev_d   = last_q;
`endif
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // Simultaneous accept and pop leave the occupancy unchanged.
        case ({accept_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage registers; cleared on reset so stale data never escapes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Control and history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            last_q   <= {WIDTH{1'b0}};
`ifdef OP_COMBINE_HIST_EN
            prev_q   <= {WIDTH{1'b0}};
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
`ifdef OP_COMBINE_HIST_EN
            prev_q   <= prev_d;
`endif
        end
    end

endmodule
